ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  EX-stage M-extension instruction valid (ID/EX output, not a nop).
REQ-005 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports operand_a and operand_b  input  32  rs1/rs2 values after forwarding.
REQ-007 SHALL have port rd_in  input  5  destination register.
REQ-008 SHALL have port flush  input  1  kill the in-flight operation (branch/jump redirect).
REQ-009 SHALL have port stall_req  output  1  hold IF/ID and ID/EX, bubble EX/MEM.
REQ-010 SHALL have port busy  output  1  FSM not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have ports result  output  32  and rd_out  output  5, both registered.

Function
REQ-013 SHALL implement FSM IDLE, PREP, CALC, DONE; busy = (state != IDLE).
REQ-014 IDLE: start=1 and flush=0 at an edge SHALL latch op, rd_in and absolute-value operands (by signedness of op), record result sign, then go to PREP.
REQ-015 PREP SHALL go to CALC with iteration counter 0, or directly to DONE for divide special cases (REQ-019/020).
REQ-016 CALC SHALL perform one radix-2 step per cycle (shift-add multiply, 64-bit product; restoring divide) for exactly 32 cycles, then go to DONE.
REQ-017 DONE SHALL last one cycle with done=1, result/rd_out valid, and return to IDLE.
REQ-018 Normal latency: start sampled at edge E0 -> done high in the cycle after edge E0+33.
REQ-019 Divide by zero SHALL give DIV/DIVU = 0xFFFFFFFF and REM/REMU = operand_a, with done after edge E0+2.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give 0x80000000; REM of the same SHALL give 0; done after edge E0+2.
REQ-021 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32] after two's-complement sign fix-up.
REQ-022 DIV SHALL truncate toward zero; remainder sign SHALL equal the dividend sign.
REQ-023 stall_req SHALL be combinational: (state==IDLE and start and !flush) or state is PREP or CALC; it SHALL be 0 in DONE.
REQ-024 start while busy SHALL be ignored.
REQ-025 flush SHALL force IDLE at the next edge from any state, with no done pulse; flush outranks start in the same cycle.
REQ-026 result and rd_out SHALL hold their value until the next DONE.

Reset
REQ-027 reset SHALL asynchronously force state=IDLE, counter=0, and done, busy, result, rd_out and all internal operand/accumulator registers to 0.
REQ-028 stall_req SHALL be 0 while reset is asserted.
REQ-029 Reset deasserted mid-operation SHALL restart from IDLE; the aborted operation SHALL produce no done.

Structure
REQ-030 The op encodings (MUL..REMU) and the FSM state encodings SHALL live in the shared pipeline definitions package/include, not in this module.
REQ-031 The module SHALL be flat; an optional sub-module muldiv_signfix (combinational negate/abs helper) MAY be used for operand and result conditioning.

Verification
REQ-032 MUL: 0x00000007 x 0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 33 cycles after the start edge; stall_req high for 33 cycles.
REQ-033 MULH: 0x80000000 x 0x80000000 -> 0x40000000; MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-034 DIV: 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same -> 0xFFFFFFFF; rd_out equals the latched rd_in (e.g. 5'd10).
REQ-035 DIVU: 0x1234 / 0 -> 0xFFFFFFFF and REMU -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; each done 2 cycles after start.
REQ-036 flush 10 cycles into a DIV -> busy=0 after the next edge, no done; a new MUL 3 x 4 started the following cycle -> 0x0000000C.
REQ-037 reset asserted asynchronously mid-CALC -> all outputs 0 immediately; a start issued while busy is ignored (result unchanged).

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg -- shared definitions for the EX-stage RV32M multiply/divide unit.
//   md_op_e    : RV32M funct3 encodings (MUL .. REMU)
//   md_state_e : sequencer states of ex_muldiv
//   op_a_signed / op_b_signed / op_is_rem : operand-signedness and result-kind decode
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // rs1 is treated as signed for every op except the fully unsigned ones.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is signed only for the signed x signed / signed divide ops.
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix -- combinational conditional two's-complement negate.
// Used both to take magnitudes of the operands and to restore the sign of results.
//   value : input word
//   neg   : 1 = output the negation of value, 0 = pass through
//   out   : conditioned word
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] out
);

  assign out = neg ? ('0 - value) : value;

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative RV32M multiply/divide unit for the EX stage.
// Works on operand magnitudes: one radix-2 shift-add (multiply) or restoring
// (divide) step per cycle for XLEN cycles, then a sign fix-up. Divide by zero
// and signed overflow bypass the iteration with a fixed two-cycle latency.
//   clk, reset          : clock, asynchronous active-high reset
//   start, op, rd_in    : instruction valid, funct3, destination register
//   operand_a/operand_b : rs1/rs2 after forwarding
//   flush               : abort the in-flight operation (no done)
//   stall_req           : hold IF/ID and ID/EX, bubble EX/MEM
//   busy, done          : sequencer not idle, one-cycle result-valid pulse
//   result, rd_out      : registered result and destination, held until next done
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int                CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state, state_nxt;

  // Latched instruction (stage p0), iteration accumulators (p1)
  logic [2:0]       op_p0;
  logic [4:0]       rd_p0;
  logic [XLEN-1:0]  a_mag_p0, b_mag_p0;
  logic             neg_res_p0;
  logic             special_p0;
  logic [XLEN-1:0]  spec_res_p0;
  logic [XLEN-1:0]  acc_hi_p1, acc_lo_p1;
  logic [CNT_W-1:0] cnt;

  // ---- Input conditioning: signedness, magnitudes, special cases ----
  logic signed [XLEN-1:0] a_s, b_s;
  logic                   neg_a_in, neg_b_in, neg_res_in;
  logic [XLEN-1:0]        abs_a_in, abs_b_in;
  logic                   div_zero, div_ovf;
  logic [XLEN-1:0]        spec_res_in;

  assign a_s      = $signed(operand_a);
  assign b_s      = $signed(operand_b);
  assign neg_a_in = op_a_signed(op) && (a_s < 0);
  assign neg_b_in = op_b_signed(op) && (b_s < 0);
  // Remainder takes the dividend sign; every other result is the product/quotient sign.
  assign neg_res_in = op_is_rem(op) ? neg_a_in : (neg_a_in ^ neg_b_in);

  muldiv_signfix #(.W(XLEN)) u_abs_a (.value(operand_a), .neg(neg_a_in), .out(abs_a_in));
  muldiv_signfix #(.W(XLEN)) u_abs_b (.value(operand_b), .neg(neg_b_in), .out(abs_b_in));

  assign div_zero = op[2] && (operand_b == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (operand_a == INT_MIN) && (operand_b == '1);

  always_comb begin
    spec_res_in = '0;
    if (div_zero) spec_res_in = op_is_rem(op) ? operand_a : '1;
    else          spec_res_in = op_is_rem(op) ? '0 : INT_MIN;
  end

  // ---- One iteration step (p1 -> p1) ----
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_hi_p1} + (acc_lo_p1[0] ? {1'b0, a_mag_p0} : '0);
    rem_sh   = {acc_hi_p1, acc_lo_p1[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_mag_p0};
    step_hi  = '0;
    step_lo  = '0;
    if (op_p0[2]) begin
      // Restoring divide: keep the shifted remainder when the trial subtract borrows.
      step_hi = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
      step_lo = {acc_lo_p1[XLEN-2:0], ~rem_diff[XLEN]};
    end else begin
      // Shift-add multiply: carry out of the add shifts into the high half.
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo_p1[XLEN-1:1]};
    end
  end

  // ---- Result sign fix-up (p1 -> result register) ----
  logic [2*XLEN-1:0] prod_fx;
  logic [XLEN-1:0]   div_sel, div_fx, final_res;

  assign div_sel = op_is_rem(op_p0) ? step_hi : step_lo;

  muldiv_signfix #(.W(2*XLEN)) u_fix_prod (.value({step_hi, step_lo}), .neg(neg_res_p0), .out(prod_fx));
  muldiv_signfix #(.W(XLEN))   u_fix_div  (.value(div_sel), .neg(neg_res_p0), .out(div_fx));

  always_comb begin
    final_res = '0;
    if (op_p0[2])             final_res = div_fx;
    else if (op_p0[1:0] == 0) final_res = prod_fx[XLEN-1:0];
    else                      final_res = prod_fx[2*XLEN-1:XLEN];
  end

  // ---- Sequencer ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_PREP;
      // Special cases spend a second cycle in PREP so their latency is a fixed two cycles.
      ST_PREP: begin
        if (!special_p0)     state_nxt = ST_CALC;
        else if (cnt != '0)  state_nxt = ST_DONE;
      end
      ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_p0       <= '0;
      rd_p0       <= '0;
      a_mag_p0    <= '0;
      b_mag_p0    <= '0;
      neg_res_p0  <= 1'b0;
      special_p0  <= 1'b0;
      spec_res_p0 <= '0;
      acc_hi_p1   <= '0;
      acc_lo_p1   <= '0;
      cnt         <= '0;
      result      <= '0;
      rd_out      <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_p0       <= op;
            rd_p0       <= rd_in;
            a_mag_p0    <= abs_a_in;
            b_mag_p0    <= abs_b_in;
            neg_res_p0  <= neg_res_in;
            special_p0  <= div_zero | div_ovf;
            spec_res_p0 <= spec_res_in;
            cnt         <= '0;
          end
        end
        ST_PREP: begin
          if (special_p0) begin
            if (cnt == '0) begin
              cnt <= CNT_W'(1);
            end else begin
              cnt    <= '0;
              result <= spec_res_p0;
              rd_out <= rd_p0;
            end
          end else begin
            // Multiply iterates over rs2 in the low half; divide shifts the dividend out of it.
            acc_hi_p1 <= '0;
            acc_lo_p1 <= op_p0[2] ? a_mag_p0 : b_mag_p0;
            cnt       <= '0;
          end
        end
        ST_CALC: begin
          acc_hi_p1 <= step_hi;
          acc_lo_p1 <= step_lo;
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            result <= final_res;
            rd_out <= rd_p0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign stall_req = !reset &&
                     (((state == ST_IDLE) && start && !flush) ||
                      (state == ST_PREP) || (state == ST_CALC));

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv -- scoreboard bench for ex_muldiv: directed vectors push their
// hand-computed result, destination and done cycle; a monitor pops on done.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        stall_req, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
    .flush(flush), .stall_req(stall_req), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_done = 0;
  int   n_exp = 0;
  int   stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, want, $time);
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (stall_req && busy) stall_cnt++;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done with result 0x%08h, required no done (t=%0t)", result, $time);
      end else begin
        e = sb.pop_front();
        n_done++;
        chk("result", result, e.res);
        chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive one start pulse; when tracked, its expectation goes on the scoreboard.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] want, input int lat, input bit track);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; operand_a = a; operand_b = b; rd_in = rd;
    if (track) begin
      e.res = want; e.rd = rd; e.cyc = cyc + 1 + lat;
      sb.push_back(e);
      n_exp++;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL timeout: got %0d outstanding results, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] want, input int lat);
    issue(o, a, b, rd, want, lat, 1'b1);
    wait_done();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
    operand_a = '0; operand_b = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    // start held during reset must not raise stall_req
    start = 1'b1; op = OP_MUL; operand_a = 32'd9; operand_b = 32'd9; rd_in = 5'd1;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_stall", {31'b0, stall_req}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", {27'b0, rd_out}, 32'd0);
    start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;

    // MUL with stall length
    stall_cnt = 0;
    run(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33);
    chk("stall_cycles", 32'(stall_cnt), 32'd33);

    run(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33);
    run(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33);
    run(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33);
    run(OP_MUL,    32'h1234_5678, 32'h0000_0010, 5'd5,  32'h2345_6780, 33);
    run(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD, 33);
    run(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF, 33);
    run(OP_DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        33);
    run(OP_REMU,   32'd100,       32'd7,         5'd13, 32'd2,         33);
    // fast paths
    run(OP_DIVU,   32'h0000_1234, 32'h0,         5'd14, 32'hFFFF_FFFF, 2);
    run(OP_REMU,   32'h0000_1234, 32'h0,         5'd15, 32'h0000_1234, 2);
    run(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 2);
    run(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 2);
    run(OP_DIV,    32'hFFFF_FFFB, 32'h0,         5'd18, 32'hFFFF_FFFF, 2);
    run(OP_REM,    32'hFFFF_FFFB, 32'h0,         5'd19, 32'hFFFF_FFFB, 2);

    // flush ten cycles into a divide: no done, idle after the next edge
    issue(OP_DIV, 32'd1000, 32'd3, 5'd20, 32'd0, 0, 1'b0);
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    run(OP_MUL, 32'd3, 32'd4, 5'd21, 32'h0000_000C, 33);

    // start while busy is ignored; result then holds
    issue(OP_MUL, 32'd5, 32'd6, 5'd3, 32'd30, 33, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = OP_MUL; operand_a = 32'd100; operand_b = 32'd100; rd_in = 5'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result", result, 32'd30);
    chk("hold_rd_out", {27'b0, rd_out}, 32'd3);

    // asynchronous reset mid-CALC
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd9, 32'd0, 0, 1'b0);
    repeat (15) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_stall", {31'b0, stall_req}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_rd_out", {27'b0, rd_out}, 32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    chk("done_count", 32'(n_done), 32'(n_exp));
    chk("idle_after_reset", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
